// File: rtl/pipelined_adder_sub.sv
// pipelined_adder_sub
//   WIDTH-bit adder/subtractor built from a ripple of 1-bit full-adder cells,
//   cut into STAGES carry-pipelined slices of CHUNK bits each. Stage k adds
//   operand slice k with the carry registered by stage k-1. Operand slices not
//   yet consumed travel forward in skew registers. Finished result slices travel
//   forward in de-skew registers, so the last stage presents one coherent beat.
//   All stages advance together (en) with valid/ready handshakes on both sides.

module pipelined_adder_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  if ((WIDTH < 2) || (STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_param_check
    $error("pipelined_adder_sub: need WIDTH >= 2 and WIDTH a multiple of STAGES");
  end

  // Ripple of CHUNK full-adder cells.
  // Returns {carry into the top cell, carry out of the top cell, sum slice}.
  function automatic logic [CHUNK+1:0] chunk_add(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             ci
  );
    logic             c;
    logic             c_top_in;
    logic [CHUNK-1:0] s;
    c        = ci;
    c_top_in = ci;
    s        = '0;
    for (int i = 0; i < CHUNK; i++) begin
      c_top_in = c;
      s[i]     = x[i] ^ y[i] ^ c;
      c        = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c_top_in, c, s};
  endfunction

  // Per-stage pipeline registers: operand skew, result de-skew, carry, mode.
  logic [STAGES-1:0] vld_r;
  logic [WIDTH-1:0]  a_r   [STAGES];
  logic [WIDTH-1:0]  b_r   [STAGES];
  logic [WIDTH-1:0]  s_r   [STAGES];
  logic [STAGES-1:0] c_r;
  logic [STAGES-1:0] sub_r;
  logic              cout_r;
  logic              ovf_r;

  // Values entering each stage and what that stage computes from them.
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_sub;
  logic [CHUNK+1:0]  res_s [STAGES];
  logic [WIDTH-1:0]  nxt_s [STAGES];
  logic [STAGES-1:0] nxt_c;
  logic [STAGES-1:0] nxt_ctop;
  logic              en;

  // Every stage shifts together whenever the output slot is free or draining.
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_r[LAST];
  assign sum       = s_r[LAST];
  assign cout      = cout_r;
  assign ovf       = ovf_r;

  // Stage inputs (subtract folded into the operands at entry) and slice adds.
  always_comb begin
    src_a[0]   = a;
    src_b[0]   = sub ? ~b : b;
    src_s[0]   = '0;
    src_c[0]   = sub ? ~cin : cin;
    src_v[0]   = in_valid;
    src_sub[0] = sub;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k]   = a_r[k-1];
      src_b[k]   = b_r[k-1];
      src_s[k]   = s_r[k-1];
      src_c[k]   = c_r[k-1];
      src_v[k]   = vld_r[k-1];
      src_sub[k] = sub_r[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      res_s[k]                   = chunk_add(src_a[k][k*CHUNK +: CHUNK],
                                             src_b[k][k*CHUNK +: CHUNK],
                                             src_c[k]);
      nxt_s[k]                   = src_s[k];
      nxt_s[k][k*CHUNK +: CHUNK] = res_s[k][CHUNK-1:0];
      nxt_c[k]                   = res_s[k][CHUNK];
      nxt_ctop[k]                = res_s[k][CHUNK+1];
    end
  end

  // Pipeline advance; bubbles shift like beats, everything holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r  <= '0;
      c_r    <= '0;
      sub_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
      end
    end else if (en) begin
      vld_r <= src_v;
      c_r   <= nxt_c;
      sub_r <= src_sub;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= src_a[k];
        b_r[k] <= src_b[k];
        s_r[k] <= nxt_s[k];
      end
      // A carry out of the top bit means "no borrow" when subtracting.
      cout_r <= src_sub[LAST] ? ~nxt_c[LAST] : nxt_c[LAST];
      ovf_r  <= nxt_ctop[LAST] ^ nxt_c[LAST];
    end
  end

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Testbench for pipelined_adder_sub (WIDTH=32, STAGES=4).
// Stimulus pushes reference results into a queue. An independent monitor
// pops and compares on every output transfer and also checks stall behaviour.

module tb_pipelined_adder_sub;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   last_pop_cyc = 0;
  int   n_out = 0;
  int   n_wait = 0;
  res_t exp_q[$];

  pipelined_adder_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference: exact integer arithmetic, then read off wrap, carry/borrow, signed range.
  function automatic res_t ref_model(input logic [31:0] x, input logic [31:0] y,
                                     input logic ci, input logic s);
    res_t   r;
    longint ua, ub, ur, sa, sb, sr, c;
    ua = {32'd0, x};
    ub = {32'd0, y};
    c  = ci ? 64'sd1 : 64'sd0;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    if (!s) begin
      ur = ua + ub + c;
      sr = sa + sb + c;
      r.cout = (ur > 64'sd4294967295);
    end else begin
      ur = ua - ub - c;
      sr = sa - sb - c;
      r.cout = (ur < 64'sd0);
    end
    r.sum = ur[31:0];
    r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return r;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Present one beat until accepted; called and returns at posedge+1.
  task automatic send(input logic [31:0] x, input logic [31:0] y,
                      input logic ci, input logic s);
    int n;
    logic ok;
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n <= 200) begin
      @(negedge clk);
      ok = in_ready;
      if (!ok) n++;
    end
    n_wait += n;
    if (ok) begin
      exp_q.push_back(ref_model(x, y, ci, s));
      acc_cyc = cyc;
    end else begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d beats still outstanding, required 0", exp_q.size());
    end
  endtask

  // Monitor: scoreboard on every output transfer, plus stall checks.
  initial begin
    res_t got, want;
    logic [WIDTH+2:0] held;
    logic stall_prev;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          tests++;
          if ({out_valid, sum, cout, ovf} !== held) begin
            fails++;
            $display("FAIL stall_hold: got %h, required %h", {out_valid, sum, cout, ovf}, held);
          end
        end
        if (out_valid && !out_ready) begin
          tests++;
          if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL in_ready_stall: got %b, required 0", in_ready);
          end
        end
        if (out_valid && out_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL stale_beat: got sum=%h with no beat outstanding, required none", sum);
          end else begin
            want = exp_q.pop_front();
            got  = '{sum: sum, cout: cout, ovf: ovf};
            if (got !== want) begin
              fails++;
              $display("FAIL result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                       got.sum, got.cout, got.ovf, want.sum, want.cout, want.ovf);
            end
          end
          n_out++;
          last_pop_cyc = cyc;
        end
        stall_prev = out_valid && !out_ready;
        held = {out_valid, sum, cout, ovf};
      end
    end
  end

  initial begin
    int lat, base, first;
    logic bp_done;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: got v=%b sum=%h c=%b o=%b rdy=%b, required 0 0 0 0 1",
               out_valid, sum, cout, ovf, in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Wrap-around add with latency measured from the acceptance cycle.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    tests++;
    if (lat != STAGES) begin
      fails++;
      $display("FAIL latency: got %0d cycles, required %0d", lat, STAGES);
    end
    @(posedge clk); #1;
    drain();

    // Signed overflow, subtract with borrow, carry across three slice boundaries.
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    send(32'h00FF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
    drain();

    // Back-pressure: out_ready follows 1,0,0,1 while 8 beats go in back to back.
    base = n_out;
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        bp_done = 1'b1;
      end
      begin
        int j;
        j = 0;
        while ((!bp_done || exp_q.size() != 0) && j < 400) begin
          out_ready = ((j % 4) == 0) || ((j % 4) == 3);
          j++;
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    tests++;
    if (n_out - base != 8) begin
      fails++;
      $display("FAIL bp_count: got %0d results, required 8", n_out - base);
    end

    // Reset with beats in flight and one result on the output.
    for (int i = 0; i < 5; i++)
      send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rst = 1'b1;
    #1;
    tests++;
    if ({out_valid, sum, cout, ovf} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_midstream: got v=%b sum=%h c=%b o=%b, required all 0",
               out_valid, sum, cout, ovf);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    base = n_out;
    for (int i = 0; i < 12; i++) begin
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
    end
    tests++;
    if (n_out != base) begin
      fails++;
      $display("FAIL stale_after_reset: got %0d results, required 0", n_out - base);
    end

    // Full rate: 1000 random beats, one result per cycle.
    out_ready = 1'b1;
    n_wait = 0;
    base = n_out;
    send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    first = acc_cyc;
    for (int i = 1; i < 1000; i++)
      send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();
    tests++;
    if (n_wait != 0) begin
      fails++;
      $display("FAIL full_rate_stall: got %0d wait cycles, required 0", n_wait);
    end
    tests++;
    if (n_out - base != 1000) begin
      fails++;
      $display("FAIL full_rate_count: got %0d results, required 1000", n_out - base);
    end
    tests++;
    if (last_pop_cyc - first != 999 + STAGES) begin
      fails++;
      $display("FAIL full_rate_span: got %0d cycles, required %0d", last_pop_cyc - first, 999 + STAGES);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
